kyber512_keccak_arbiter: RTL
============================

// Module: kyber512_keccak_arbiter
// PURPOSE
//   Shares one Keccak/SHA3 hash core between up to NUM_REQ requesters. Requesters are the KEM
//   pre/post hash, the INDCPA matrix sampler (SHAKE128) and the noise sampler (SHAKE256).
//   Grants the core to one requester at a time, issues the core start with that requester's
//   mode, and routes core completion back to it. Guards against a hung core with a cycle timeout.
// PARAMETERS
//   NUM_REQ      4     number of requesters (2..8)
//   SEL_W        2     width of core select index; must satisfy 2**SEL_W >= NUM_REQ
//   MODE_W       2     hash mode code: 0=SHA3-256, 1=SHA3-512, 2=SHAKE128, 3=SHAKE256
//   TIMEOUT_CYC  4096  max cycles in WAIT before abort
//   TO_W         13    timeout counter width; must hold TIMEOUT_CYC
// PORTS
//   clk            in   1               clock, rising edge
//   rst_n          in   1               asynchronous reset, active-low
//   i_req          in   NUM_REQ         request level per requester; held high until its o_done
//   i_mode         in   NUM_REQ*MODE_W  mode of requester k at [k*MODE_W +: MODE_W]
//   o_grant        out  NUM_REQ         one-hot; high for the owner during WAIT only
//   o_done         out  NUM_REQ         1-cycle completion pulse to the owner
//   o_core_start   out  1               1-cycle start pulse to hash core
//   o_core_mode    out  MODE_W          mode latched at grant; stable START..RELEASE
//   o_core_sel     out  SEL_W           owner index; steers the core's input/output muxes
//   i_core_done    in   1               hash core completion pulse
//   o_busy         out  1               high in any state other than IDLE
//   o_timeout_err  out  1               sticky; set on timeout, cleared only by rst_n
// BEHAVIOUR
//   Reset: state=IDLE, all outputs 0, rr pointer=0, timeout counter=0.
//   FSM: IDLE -> WAIT -> RELEASE -> IDLE. All outputs are registered.
//   IDLE:
//     - If i_req!=0: pick the winner, latch o_core_sel/o_core_mode, go to WAIT.
//     - Winner = first set bit searching upward from rr pointer, wrapping NUM_REQ-1 -> 0.
//   Latency:
//     - req seen in IDLE at cycle N -> o_grant and o_core_start high at N+1.
//     - o_core_start lasts exactly 1 cycle; o_grant holds for the whole WAIT.
//   WAIT:
//     - Counter increments each cycle. i_core_done in the o_core_start cycle is ignored.
//     - i_core_done at cycle M -> RELEASE at M+1: o_done[sel]=1 for 1 cycle, o_grant=0.
//     - rr pointer <= (sel+1) mod NUM_REQ. Back to IDLE at M+2; earliest next grant is M+3.
//   Timeout:
//     - Counter reaches TIMEOUT_CYC-1 without i_core_done -> o_timeout_err<=1, o_grant<=0, IDLE.
//     - No o_done is issued; rr pointer still advances past the aborted requester.
//     - A late i_core_done arriving in IDLE is ignored.
//   Boundary cases:
//     - Owner drops i_req mid-WAIT: no abort. The core finishes and o_done still pulses.
//     - i_req/i_mode changes of non-owners during WAIT have no effect.
//     - i_mode of the owner is not re-sampled after the grant.
//     - Simultaneous i_core_done and timeout in the same cycle: done wins, normal RELEASE.
//     - Requester re-asserting i_req in the RELEASE cycle waits its round-robin turn.
//     - rst_n low mid-WAIT: immediate return to reset values; the core is reset on the same rst_n.
// CONFIGURATION
//   KYBER_ARB_PRIORITY_EN defined:
//     - Requester 0 (KEM pre/post hash) wins whenever i_req[0]=1.
//     - Requesters 1..NUM_REQ-1 share round-robin; the pointer only tracks those grants.
//   Undefined: pure round-robin over all NUM_REQ requesters.
// TESTING
//   1. Reset, i_req=4'b0100 with mode 2 at cycle 0 -> cycle 1: o_grant=0100, o_core_start=1,
//      o_core_mode=2, o_core_sel=2. core done at cycle 20 -> o_done=0100 at 21, o_busy=0 at 22.
//   2. i_req=4'b1111 held, core done 5 cycles after each start, macro off
//      -> grant order 0,1,2,3,0; each o_done is a single cycle.
//   3. Macro on, i_req=4'b1110 held, then i_req[0] raised while requester 1 is in WAIT
//      -> requester 1 completes, next grant goes to 0, then 2.
//   4. Never assert i_core_done -> o_timeout_err=1 and o_grant=0 exactly TIMEOUT_CYC cycles
//      after the start; no o_done pulse; next request is granted normally.
//   5. Owner drops i_req mid-WAIT -> o_done still pulses. Assert rst_n=0 mid-WAIT
//      -> all outputs 0 asynchronously and o_timeout_err cleared.
//   6. i_core_done in the same cycle as the timeout terminal count -> o_done pulses,
//      o_timeout_err stays 0.

Source files
------------

// File: rtl/kyber512_keccak_arbiter_if.sv
// Request/grant and hash-core handshake bundle for the Keccak arbiter.
// master: arbiter side; slave: requesters and hash core side.
interface kyber512_keccak_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2,
  parameter int MODE_W  = 2
);
  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*MODE_W-1:0] i_mode;
  logic [NUM_REQ-1:0]        o_grant;
  logic [NUM_REQ-1:0]        o_done;
  logic                      o_core_start;
  logic [MODE_W-1:0]         o_core_mode;
  logic [SEL_W-1:0]          o_core_sel;
  logic                      i_core_done;
  logic                      o_busy;
  logic                      o_timeout_err;

  modport master (
    input  i_req, i_mode, i_core_done,
    output o_grant, o_done, o_core_start,
    output o_core_mode, o_core_sel,
    output o_busy, o_timeout_err
  );

  modport slave (
    output i_req, i_mode, i_core_done,
    input  o_grant, o_done, o_core_start,
    input  o_core_mode, o_core_sel,
    input  o_busy, o_timeout_err
  );
endinterface

// File: rtl/kyber512_keccak_arbiter.sv
// Shares one Keccak core between NUM_REQ requesters (round-robin, timeout guard).
// Ports: clk, rst_n (async, active-low), bus (master modport).
// Optional: KYBER_ARB_PRIORITY_EN gives requester 0 absolute priority.
module kyber512_keccak_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int SEL_W       = 2,
  parameter int MODE_W      = 2,
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_W        = 13
) (
  input logic clk,
  input logic rst_n,
  kyber512_keccak_arbiter_if.master bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT_CYC - 1);

  logic [1:0]         state;
  logic [SEL_W-1:0]   rr;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   win;
  logic [SEL_W-1:0]   sel_nxt;
  logic [SEL_W-1:0]   rr_nxt;
  logic [TO_W-1:0]    cnt;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] rmask;
  logic [MODE_W-1:0]  mode;
  logic [MODE_W-1:0]  win_mode;
  logic               start;
  logic               busy;
  logic               err;
  logic               found;

  assign sel_nxt = (sel == SEL_W'(NUM_REQ - 1)) ?
                   '0 : sel + SEL_W'(1);

`ifdef KYBER_ARB_PRIORITY_EN
  // pointer only follows grants of the shared requesters
  assign rr_nxt = (sel == '0) ? rr : sel_nxt;
`else
  assign rr_nxt = sel_nxt;
`endif

  // two passes: indices >= rr first, then the wrapped-around ones
  always_comb begin
    rmask    = bus.i_req;
    found    = 1'b0;
    win      = '0;
    win_mode = '0;
`ifdef KYBER_ARB_PRIORITY_EN
    if (bus.i_req[0]) begin
      found    = 1'b1;
      win_mode = bus.i_mode[MODE_W-1:0];
    end
    rmask[0] = 1'b0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rmask[k] && SEL_W'(k) >= rr) begin
        found    = 1'b1;
        win      = SEL_W'(k);
        win_mode = bus.i_mode[k*MODE_W +: MODE_W];
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rmask[k]) begin
        found    = 1'b1;
        win      = SEL_W'(k);
        win_mode = bus.i_mode[k*MODE_W +: MODE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rr    <= '0;
      sel   <= '0;
      mode  <= '0;
      cnt   <= '0;
      grant <= '0;
      done  <= '0;
      start <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      start <= 1'b0;
      done  <= '0;
      unique case (state)
        S_IDLE: begin
          if (found) begin
            state <= S_WAIT;
            grant <= NUM_REQ'(1) << win;
            start <= 1'b1;
            sel   <= win;
            mode  <= win_mode;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        S_WAIT: begin
          cnt <= cnt + TO_W'(1);
          // a done coincident with start belongs to no job
          if (bus.i_core_done && !start) begin
            state <= S_REL;
            done  <= grant;
            grant <= '0;
            rr    <= rr_nxt;
          end else if (cnt == TO_LAST) begin
            state <= S_IDLE;
            grant <= '0;
            busy  <= 1'b0;
            err   <= 1'b1;
            rr    <= rr_nxt;
          end
        end
        S_REL: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_grant       = grant;
  assign bus.o_done        = done;
  assign bus.o_core_start  = start;
  assign bus.o_core_mode   = mode;
  assign bus.o_core_sel    = sel;
  assign bus.o_busy        = busy;
  assign bus.o_timeout_err = err;
endmodule
